branch_target_predictor: RTL and testbench

Fetch-stage branch predictor that produces the `bpred` record (`.is_branch`, `.decision`, `.pred_addr`) consumed by the execute-stage prediction checker. It holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry. Lookup is combinational on the fetch PC. The table is trained from the resolved-branch update interface driven by the execute stage.

---
 rtl/branch_target_predictor.sv | 179 +++++++++++++++++
 tb/tb_branch_target_predictor.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, trained from execute.
// Define BP_TAG_CHECK_EN to store and compare tags; otherwise hit = valid.
package bp_pkg;
  typedef logic [31:0] addrPC_t;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } branch_decision_t;

  typedef enum logic [3:0] {
    ADD, SUB, LOAD, STORE,
    BEQ, BNE, BLT, BLTU, BGE, BGEU,
    JAL, JALR
  } instr_type_t;

  typedef struct packed {
    logic             is_branch;
    branch_decision_t decision;
    addrPC_t          pred_addr;
  } branch_pred_t;
endpackage

module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             fetch_valid_i,
  input  addrPC_t          fetch_pc_i,
  output branch_pred_t     bpred_o,
  input  logic             upd_valid_i,
  input  logic             stall_i,
  input  addrPC_t          upd_pc_i,
  input  instr_type_t      upd_instr_type_i,
  input  branch_decision_t upd_taken_i,
  input  addrPC_t          upd_target_i,
  input  logic             upd_correct_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] miss_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         cnt_q [ENTRIES];
  addrPC_t            tgt_q [ENTRIES];
  logic [CNT_W-1:0]   miss_q;

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] u_idx;
  logic             f_hit;
  logic             u_hit;
  logic             f_match;
  logic             u_match;

  assign f_idx = fetch_pc_i[IDX_W+1:2];
  assign u_idx = upd_pc_i[IDX_W+1:2];

`ifdef BP_TAG_CHECK_EN
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [TAG_W-1:0] f_tag;
  logic [TAG_W-1:0] u_tag;

  assign f_tag   = fetch_pc_i[TAG_W+IDX_W+1:IDX_W+2];
  assign u_tag   = upd_pc_i[TAG_W+IDX_W+1:IDX_W+2];
  assign f_match = (tag_q[f_idx] == f_tag);
  assign u_match = (tag_q[u_idx] == u_tag);
`else
  assign f_match = 1'b1;
  assign u_match = 1'b1;
`endif

  logic unused_bits;
  assign unused_bits = ^{fetch_pc_i, upd_pc_i};

  // Lookup reads the registered table only, so same-cycle updates are unseen
  assign f_hit = fetch_valid_i & valid_q[f_idx] & f_match;

  always_comb begin
    bpred_o           = '0;
    bpred_o.is_branch = f_hit;
    bpred_o.decision  = (f_hit && cnt_q[f_idx][1]) ? TAKEN : NOT_TAKEN;
    if (bpred_o.decision == TAKEN)
      bpred_o.pred_addr = tgt_q[f_idx];
    else if (fetch_valid_i)
      bpred_o.pred_addr = fetch_pc_i + 32'd4;
    else
      bpred_o.pred_addr = '0;
  end

  logic       accept;
  logic       is_cond;
  logic       is_jump;
  logic       taken;
  logic       wr_en;
  logic       nxt_valid;
  logic [1:0] nxt_cnt;
  addrPC_t    nxt_tgt;

  assign accept  = upd_valid_i & ~stall_i & ~flush_i;
  assign u_hit   = valid_q[u_idx] & u_match;
  assign taken   = (upd_taken_i == TAKEN);
  assign is_cond = upd_instr_type_i inside {BEQ, BNE, BLT, BLTU, BGE, BGEU};
  assign is_jump = upd_instr_type_i inside {JAL, JALR};

  always_comb begin
    wr_en     = 1'b0;
    nxt_valid = valid_q[u_idx];
    nxt_cnt   = cnt_q[u_idx];
    nxt_tgt   = tgt_q[u_idx];
    unique case (1'b1)
      is_cond: begin
        if (u_hit) begin
          wr_en = 1'b1;
          if (taken) begin
            nxt_tgt = upd_target_i;
            if (nxt_cnt != 2'b11) nxt_cnt = nxt_cnt + 2'd1;
          end else if (nxt_cnt != 2'b00) begin
            nxt_cnt = nxt_cnt - 2'd1;
          end
        end else if (taken) begin
          wr_en     = 1'b1;
          nxt_valid = 1'b1;
          nxt_tgt   = upd_target_i;
          nxt_cnt   = 2'b10;
        end
      end
      is_jump: begin
        wr_en     = 1'b1;
        nxt_valid = 1'b1;
        nxt_tgt   = upd_target_i;
        nxt_cnt   = 2'b11;
      end
      default: begin
        // Non-branch resolved at a BTB hit: purge the aliasing entry
        if (u_hit) begin
          wr_en     = 1'b1;
          nxt_valid = 1'b0;
        end
      end
    endcase
    wr_en = wr_en & accept;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      miss_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
        tgt_q[i] <= '0;
`ifdef BP_TAG_CHECK_EN
        tag_q[i] <= '0;
`endif
      end
    end else begin
      if (flush_i) begin
        valid_q <= '0;
      end else if (wr_en) begin
        valid_q[u_idx] <= nxt_valid;
        cnt_q[u_idx]   <= nxt_cnt;
        tgt_q[u_idx]   <= nxt_tgt;
`ifdef BP_TAG_CHECK_EN
        tag_q[u_idx]   <= u_tag;
`endif
      end
      if (accept && !upd_correct_i && (miss_q != '1))
        miss_q <= miss_q + CNT_W'(1);
    end
  end

  assign miss_count_o = miss_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor (CNT_W=2 to reach saturation).
// Expectations adapt to whether BP_TAG_CHECK_EN is defined.
module tb_branch_target_predictor;
  import bp_pkg::*;

  logic             clk;
  logic             rstn;
  logic             fetch_valid;
  addrPC_t          fetch_pc;
  branch_pred_t     bpred;
  logic             upd_valid;
  logic             stall;
  addrPC_t          upd_pc;
  instr_type_t      upd_type;
  branch_decision_t upd_taken;
  addrPC_t          upd_target;
  logic             upd_correct;
  logic             flush;
  logic [1:0]       miss_count;

  int         n_checks;
  int         n_fail;
  logic [1:0] exp_miss;

  branch_target_predictor #(
    .ENTRIES(16),
    .TAG_W  (8),
    .CNT_W  (2)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .fetch_valid_i   (fetch_valid),
    .fetch_pc_i      (fetch_pc),
    .bpred_o         (bpred),
    .upd_valid_i     (upd_valid),
    .stall_i         (stall),
    .upd_pc_i        (upd_pc),
    .upd_instr_type_i(upd_type),
    .upd_taken_i     (upd_taken),
    .upd_target_i    (upd_target),
    .upd_correct_i   (upd_correct),
    .flush_i         (flush),
    .miss_count_o    (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic branch_pred_t mk(input logic ib,
                                      input branch_decision_t d,
                                      input addrPC_t a);
    branch_pred_t r;
    r.is_branch = ib;
    r.decision  = d;
    r.pred_addr = a;
    return r;
  endfunction

  task automatic upd(input addrPC_t pc, input instr_type_t t,
                     input branch_decision_t tk, input addrPC_t tgt,
                     input logic corr, input logic stl, input logic fl);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_type    = t;
    upd_taken   = tk;
    upd_target  = tgt;
    upd_correct = corr;
    stall       = stl;
    flush       = fl;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    if (!stl && !fl && !corr && exp_miss != 2'b11)
      exp_miss = exp_miss + 2'd1;
  endtask

  task automatic lookup(input addrPC_t pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    #1;
  endtask

  task automatic test_reset;
    branch_pred_t e;
    rstn = 1'b0;
    #3;
    e = mk(1'b0, NOT_TAKEN, 32'h0);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL reset_idle got %h want %h", bpred, e);
    end
    n_checks++;
    if (miss_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_miss got %0d want 0", miss_count);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    lookup(32'h100);
    e = mk(1'b0, NOT_TAKEN, 32'h104);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL reset_lookup got %h want %h", bpred, e);
    end
  endtask

  task automatic test_train;
    branch_pred_t e;
    upd(32'h100, BEQ, TAKEN, 32'h80, 1'b0, 1'b0, 1'b0);
    lookup(32'h100);
    e = mk(1'b1, TAKEN, 32'h80);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL train_alloc got %h want %h", bpred, e);
    end
    n_checks++;
    if (miss_count !== exp_miss) begin
      n_fail++;
      $display("FAIL train_miss got %0d want %0d", miss_count, exp_miss);
    end
    fetch_valid = 1'b0;
    #1;
    e = mk(1'b0, NOT_TAKEN, 32'h0);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL train_novalid got %h want %h", bpred, e);
    end
    // counter 10 -> 01
    upd(32'h100, BEQ, NOT_TAKEN, 32'h80, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
    e = mk(1'b1, NOT_TAKEN, 32'h104);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL train_weaknt got %h want %h", bpred, e);
    end
    // 01 -> 10 -> 11 -> 11
    for (int i = 0; i < 3; i++)
      upd(32'h100, BEQ, TAKEN, 32'h80, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
    e = mk(1'b1, TAKEN, 32'h80);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL train_sat_hi got %h want %h", bpred, e);
    end
    // 11 -> 10 stays taken
    upd(32'h100, BEQ, NOT_TAKEN, 32'h80, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL train_strong got %h want %h", bpred, e);
    end
    // 10 -> 01 -> 00 -> 00
    for (int i = 0; i < 3; i++)
      upd(32'h100, BEQ, NOT_TAKEN, 32'h80, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
    e = mk(1'b1, NOT_TAKEN, 32'h104);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL train_sat_lo got %h want %h", bpred, e);
    end
    // 00 -> 01 still not taken
    upd(32'h100, BEQ, TAKEN, 32'h80, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL train_up1 got %h want %h", bpred, e);
    end
    // 01 -> 10 with new target
    upd(32'h100, BNE, TAKEN, 32'hA0, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
    e = mk(1'b1, TAKEN, 32'hA0);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL train_retarget got %h want %h", bpred, e);
    end
    upd(32'h100, BEQ, TAKEN, 32'h80, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_alias;
    branch_pred_t e;
    lookup(32'h140);
`ifdef BP_TAG_CHECK_EN
    e = mk(1'b0, NOT_TAKEN, 32'h144);
`else
    e = mk(1'b1, TAKEN, 32'h80);
`endif
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL alias_lookup got %h want %h", bpred, e);
    end
    upd(32'h140, ADD, NOT_TAKEN, 32'h0, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
`ifdef BP_TAG_CHECK_EN
    e = mk(1'b1, TAKEN, 32'h80);
`else
    e = mk(1'b0, NOT_TAKEN, 32'h104);
`endif
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL alias_add_other got %h want %h", bpred, e);
    end
    upd(32'h100, ADD, NOT_TAKEN, 32'h0, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
    e = mk(1'b0, NOT_TAKEN, 32'h104);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL alias_add_hit got %h want %h", bpred, e);
    end
    upd(32'h100, BNE, NOT_TAKEN, 32'h90, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL alias_nt_miss got %h want %h", bpred, e);
    end
  endtask

  task automatic test_stall_flush;
    branch_pred_t e;
    upd(32'h200, JAL, TAKEN, 32'h400, 1'b0, 1'b1, 1'b0);
    lookup(32'h200);
    e = mk(1'b0, NOT_TAKEN, 32'h204);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL stall_drop got %h want %h", bpred, e);
    end
    n_checks++;
    if (miss_count !== exp_miss) begin
      n_fail++;
      $display("FAIL stall_miss got %0d want %0d", miss_count, exp_miss);
    end
    upd(32'h200, JAL, TAKEN, 32'h400, 1'b1, 1'b0, 1'b0);
    lookup(32'h200);
    e = mk(1'b1, TAKEN, 32'h400);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL jal_alloc got %h want %h", bpred, e);
    end
    upd_valid   = 1'b1;
    upd_pc      = 32'h300;
    upd_type    = JALR;
    upd_taken   = TAKEN;
    upd_target  = 32'h10;
    upd_correct = 1'b0;
    flush       = 1'b1;
    #1;
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL flush_same_cycle got %h want %h", bpred, e);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    flush     = 1'b0;
    lookup(32'h200);
    e = mk(1'b0, NOT_TAKEN, 32'h204);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL flush_200 got %h want %h", bpred, e);
    end
    lookup(32'h300);
    e = mk(1'b0, NOT_TAKEN, 32'h304);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL flush_300 got %h want %h", bpred, e);
    end
    n_checks++;
    if (miss_count !== exp_miss) begin
      n_fail++;
      $display("FAIL flush_miss got %0d want %0d", miss_count, exp_miss);
    end
  endtask

  task automatic test_same_cycle;
    branch_pred_t e;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    upd_valid   = 1'b1;
    upd_pc      = 32'h100;
    upd_type    = BEQ;
    upd_taken   = TAKEN;
    upd_target  = 32'h80;
    upd_correct = 1'b1;
    #1;
    e = mk(1'b0, NOT_TAKEN, 32'h104);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL rw_before got %h want %h", bpred, e);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    e = mk(1'b1, TAKEN, 32'h80);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL rw_after got %h want %h", bpred, e);
    end
  endtask

  task automatic test_miss_sat;
    for (int i = 0; i < 5; i++) begin
      upd(32'h504, ADD, NOT_TAKEN, 32'h0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (miss_count !== exp_miss) begin
        n_fail++;
        $display("FAIL miss_sat_%0d got %0d want %0d", i, miss_count, exp_miss);
      end
    end
  endtask

  task automatic test_async_reset;
    branch_pred_t e;
    upd_valid   = 1'b1;
    upd_pc      = 32'h600;
    upd_type    = JAL;
    upd_taken   = TAKEN;
    upd_target  = 32'h700;
    upd_correct = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    rstn        = 1'b0;
    exp_miss    = 2'd0;
    #1;
    n_checks++;
    if (miss_count !== exp_miss) begin
      n_fail++;
      $display("FAIL areset_miss got %0d want 0", miss_count);
    end
    e = mk(1'b0, NOT_TAKEN, 32'h104);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL areset_table got %h want %h", bpred, e);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    rstn      = 1'b1;
    lookup(32'h600);
    e = mk(1'b0, NOT_TAKEN, 32'h604);
    n_checks++;
    if (bpred !== e) begin
      n_fail++;
      $display("FAIL areset_pending got %h want %h", bpred, e);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    exp_miss    = 2'd0;
    rstn        = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc    = '0;
    upd_valid   = 1'b0;
    stall       = 1'b0;
    upd_pc      = '0;
    upd_type    = ADD;
    upd_taken   = NOT_TAKEN;
    upd_target  = '0;
    upd_correct = 1'b1;
    flush       = 1'b0;
    test_reset();
    test_train();
    test_alias();
    test_stall_flush();
    test_same_cycle();
    test_miss_sat();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
